// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline-side signal bundle for the hazard controller
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs_i;
  logic [4:0]  id_rt_i;
  logic        id_uses_rt_i;
  logic [4:0]  ex_rd_i;
  logic        ex_mem_read_i;
  logic        md_start_i;
  logic        br_taken_i;
  logic [15:0] br_target_i;
  logic        mem_wait_i;
  logic        haz_o;
  logic        bubble_o;
  logic        flush_o;
  logic [15:0] cnt_jmp_o;
  logic        md_busy_o;
  logic [15:0] stall_cnt_o;

  modport master (
    output id_rs_i, id_rt_i, id_uses_rt_i, ex_rd_i, ex_mem_read_i,
           md_start_i, br_taken_i, br_target_i, mem_wait_i,
    input  haz_o, bubble_o, flush_o, cnt_jmp_o, md_busy_o, stall_cnt_o
  );

  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rt_i, ex_rd_i, ex_mem_read_i,
           md_start_i, br_taken_i, br_target_i, mem_wait_i,
    output haz_o, bubble_o, flush_o, cnt_jmp_o, md_busy_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline hazard controller
// Load-use, mul/div hold, branch redirect/flush, memory wait and stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MD_CYCLES    = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input logic               clk_i,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_MD_BUSY = 2'd1,
    S_FLUSH   = 2'd2
  } state_t;

  localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES);
  localparam logic [2:0] FL_LOAD = 3'(FLUSH_CYCLES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_md_cnt;
  logic [7:0]  w_md_cnt_nxt;
  logic [2:0]  r_fl_cnt;
  logic [2:0]  w_fl_cnt_nxt;
  logic [15:0] r_jmp;
  logic [15:0] w_jmp_nxt;
  logic [15:0] r_stall_cnt;
  logic        w_load_use;
  logic        w_md_busy;
  logic        w_haz;

  // Load-use is only meaningful in RUN; the bubble it inserts clears it next cycle.
  always_comb begin
    w_load_use = 1'b0;
    if (r_state == S_RUN && bus.ex_mem_read_i && bus.ex_rd_i != 5'd0) begin
      w_load_use = (bus.ex_rd_i == bus.id_rs_i) ||
                   (bus.id_uses_rt_i && bus.ex_rd_i == bus.id_rt_i);
    end
  end

  assign w_md_busy = (r_state == S_MD_BUSY);
  assign w_haz     = bus.mem_wait_i | w_md_busy | w_load_use;

  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    w_fl_cnt_nxt = r_fl_cnt;
    w_jmp_nxt    = r_jmp;
    if (!bus.mem_wait_i) begin
      case (r_state)
        S_RUN: begin
          if (bus.br_taken_i && bus.br_target_i != 16'd0) begin
            w_state_nxt  = S_FLUSH;
            w_fl_cnt_nxt = FL_LOAD;
            w_jmp_nxt    = bus.br_target_i;
          end else if (bus.md_start_i) begin
            w_state_nxt  = S_MD_BUSY;
            w_md_cnt_nxt = MD_LOAD;
          end
        end
        S_MD_BUSY: begin
          w_md_cnt_nxt = r_md_cnt - 8'd1;
          if (r_md_cnt <= 8'd1) begin
            w_md_cnt_nxt = 8'd0;
            w_state_nxt  = S_RUN;
          end
        end
        S_FLUSH: begin
          // Target is presented for the first flush cycle only.
          w_jmp_nxt    = 16'd0;
          w_fl_cnt_nxt = r_fl_cnt - 3'd1;
          if (r_fl_cnt <= 3'd1) begin
            w_fl_cnt_nxt = 3'd0;
            w_state_nxt  = S_RUN;
          end
        end
        default: begin
          w_state_nxt = S_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_RUN;
      r_md_cnt <= 8'd0;
      r_fl_cnt <= 3'd0;
      r_jmp    <= 16'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
      r_fl_cnt <= w_fl_cnt_nxt;
      r_jmp    <= w_jmp_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'd0;
    end else if (w_haz && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.haz_o       = w_haz;
  assign bus.bubble_o    = w_md_busy | w_load_use;
  assign bus.flush_o     = (r_state == S_FLUSH);
  assign bus.md_busy_o   = w_md_busy;
  assign bus.cnt_jmp_o   = r_jmp;
  assign bus.stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [15:0] exp_stall;

  pipe_hazard_ctrl_if bus();

  pipe_hazard_ctrl #(.MD_CYCLES(4), .FLUSH_CYCLES(2)) dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_outs(input string tag, input logic haz, input logic bub,
                          input logic fl, input logic md, input logic [15:0] jmp);
    chk({tag, "/haz"},    {15'd0, bus.haz_o},     {15'd0, haz});
    chk({tag, "/bubble"}, {15'd0, bus.bubble_o},  {15'd0, bub});
    chk({tag, "/flush"},  {15'd0, bus.flush_o},   {15'd0, fl});
    chk({tag, "/mdbusy"}, {15'd0, bus.md_busy_o}, {15'd0, md});
    chk({tag, "/jmp"},    bus.cnt_jmp_o,          jmp);
  endtask

  // One clock edge; returns in the low phase, well away from the rising edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_rs_i = 5'd0; bus.id_rt_i = 5'd0; bus.id_uses_rt_i = 1'b0;
    bus.ex_rd_i = 5'd0; bus.ex_mem_read_i = 1'b0; bus.md_start_i = 1'b0;
    bus.br_taken_i = 1'b0; bus.br_target_i = 16'd0; bus.mem_wait_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    step();
    chk_outs("reset", 0, 0, 0, 0, 16'h0000);
    chk("reset/stall", bus.stall_cnt_o, 16'd0);
    rst_n = 1'b1;
    exp_stall = 16'd0;
    step();

    // load-use on rs
    bus.ex_mem_read_i = 1'b1; bus.ex_rd_i = 5'd5; bus.id_rs_i = 5'd5;
    #1 chk_outs("lu_rs", 1, 1, 0, 0, 16'h0000);
    step();
    exp_stall = exp_stall + 16'd1;
    idle();
    #1 chk_outs("lu_clear", 0, 0, 0, 0, 16'h0000);
    chk("lu_stall", bus.stall_cnt_o, exp_stall);
    bus.ex_mem_read_i = 1'b1; bus.ex_rd_i = 5'd0; bus.id_rs_i = 5'd0;
    #1 chk("lu_r0/haz", {15'd0, bus.haz_o}, 16'd0);

    // rt gating
    bus.ex_rd_i = 5'd7; bus.id_rt_i = 5'd7; bus.id_rs_i = 5'd3; bus.id_uses_rt_i = 1'b1;
    #1 chk_outs("rt_used", 1, 1, 0, 0, 16'h0000);
    bus.id_uses_rt_i = 1'b0;
    #1 chk_outs("rt_unused", 0, 0, 0, 0, 16'h0000);
    idle();
    step();
    chk("rt_stall", bus.stall_cnt_o, exp_stall);

    // mul/div hold, with a load-use during MD_BUSY
    bus.md_start_i = 1'b1;
    #1 chk_outs("md_pre", 0, 0, 0, 0, 16'h0000);
    step();
    bus.md_start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        bus.ex_mem_read_i = 1'b1; bus.ex_rd_i = 5'd9; bus.id_rs_i = 5'd9;
      end else begin
        idle();
      end
      #1 chk_outs($sformatf("md_c%0d", i), 1, 1, 0, 1, 16'h0000);
      step();
    end
    exp_stall = exp_stall + 16'd4;
    chk_outs("md_done", 0, 0, 0, 0, 16'h0000);
    chk("md_stall", bus.stall_cnt_o, exp_stall);

    // taken branch redirect and flush
    bus.br_taken_i = 1'b1; bus.br_target_i = 16'h0040;
    #1 chk_outs("br_pre", 0, 0, 0, 0, 16'h0000);
    step();
    idle();
    #1 chk_outs("br_f1", 0, 0, 1, 0, 16'h0040);
    step();
    chk_outs("br_f2", 0, 0, 1, 0, 16'h0000);
    step();
    chk_outs("br_done", 0, 0, 0, 0, 16'h0000);
    bus.br_taken_i = 1'b1; bus.br_target_i = 16'h0000;
    step();
    idle();
    #1 chk_outs("br_t0", 0, 0, 0, 0, 16'h0000);
    chk("br_stall", bus.stall_cnt_o, exp_stall);

    // mem_wait is combinational into haz only
    bus.mem_wait_i = 1'b1;
    #1 chk_outs("mw_run", 1, 0, 0, 0, 16'h0000);
    bus.mem_wait_i = 1'b0;
    #1 chk("mw_off/haz", {15'd0, bus.haz_o}, 16'd0);

    // mem_wait stretches MD_BUSY
    bus.md_start_i = 1'b1;
    step();
    bus.md_start_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.mem_wait_i = (i >= 1 && i <= 3);
      #1 chk_outs($sformatf("mdw_c%0d", i), 1, 1, 0, 1, 16'h0000);
      step();
    end
    bus.mem_wait_i = 1'b0;
    exp_stall = exp_stall + 16'd7;
    #1 chk_outs("mdw_done", 0, 0, 0, 0, 16'h0000);
    chk("mdw_stall", bus.stall_cnt_o, exp_stall);

    // async reset mid-flush
    bus.br_taken_i = 1'b1; bus.br_target_i = 16'h1234;
    step();
    idle();
    #1 chk_outs("ar_f1", 0, 0, 1, 0, 16'h1234);
    #1 rst_n = 1'b0;
    #1 chk_outs("ar_rst", 0, 0, 0, 0, 16'h0000);
    chk("ar_stall", bus.stall_cnt_o, 16'd0);
    step();
    rst_n = 1'b1;
    exp_stall = 16'd0;
    step();
    chk_outs("ar_post", 0, 0, 0, 0, 16'h0000);

    // branch beats simultaneous md_start
    bus.br_taken_i = 1'b1; bus.br_target_i = 16'h0080; bus.md_start_i = 1'b1;
    step();
    idle();
    #1 chk_outs("bm_f1", 0, 0, 1, 0, 16'h0080);
    step();
    chk_outs("bm_f2", 0, 0, 1, 0, 16'h0000);
    step();
    chk_outs("bm_done", 0, 0, 0, 0, 16'h0000);
    chk("bm_stall", bus.stall_cnt_o, exp_stall);

    // saturation: 65534 wait cycles reach FFFE, three more saturate
    bus.mem_wait_i = 1'b1;
    repeat (65534) step();
    chk("sat_fffe", bus.stall_cnt_o, 16'hFFFE);
    repeat (3) step();
    chk("sat_ffff", bus.stall_cnt_o, 16'hFFFF);
    bus.mem_wait_i = 1'b0;
    step();
    chk("sat_hold", bus.stall_cnt_o, 16'hFFFF);
    chk_outs("sat_idle", 0, 0, 0, 0, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
